// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-lot car sensor chain.
package parking_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      P2   = 3'd2,
      P3   = 3'd3,
      GAP  = 3'd4
   } emu_state_t;

   localparam logic DIR_ENTER = 1'b0;
   localparam logic DIR_EXIT  = 1'b1;

   localparam logic [1:0] AB_CLEAR = 2'b00;
   localparam logic [1:0] AB_A     = 2'b10;
   localparam logic [1:0] AB_BOTH  = 2'b11;
   localparam logic [1:0] AB_B     = 2'b01;

   // Beam pattern for a phase; P1/P3 swap with direction, P2 always blocks both.
   function automatic logic [1:0] phase_ab(input emu_state_t st, input logic dir);
      logic [1:0] ab;
      ab = AB_CLEAR;
      case (st)
         P1:      ab = (dir == DIR_ENTER) ? AB_A : AB_B;
         P2:      ab = AB_BOTH;
         P3:      ab = (dir == DIR_EXIT) ? AB_A : AB_B;
         default: ab = AB_CLEAR;
      endcase
      return ab;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell timer: counts 0..PHASE_CYCLES-1, flags the last cycle, restarts on clear.
module phase_timer #(
   parameter int unsigned PHASE_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic expire
);

   localparam int unsigned CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Free-running dwell count, wraps at the end of a phase or on a state change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/car_sensor_emulator.sv
// Emits the two-beam a/b waveform of a car entering or leaving, with back-out abort.
module car_sensor_emulator
   import parking_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic cmd_valid,
   input  logic cmd_dir,
   output logic cmd_ready,
   input  logic abort,
   output logic a,
   output logic b,
   output logic busy,
   output logic done,
   output logic aborted
);

   emu_state_t state;
   emu_state_t state_next;

   logic       dir;
   logic       dir_next;
   logic       rev;
   logic       rev_next;
   logic [1:0] ab_next;
   logic       done_next;
   logic       aborted_next;
   logic       busy_next;
   logic       expire;
   logic       timer_clear;
   logic       accept;
   logic       back_out;
   logic       in_phase;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign in_phase  = (state == P1) || (state == P2) || (state == P3);
   // Only the first abort of a sequence reverses it; the reverse path runs to completion.
   assign back_out  = abort && !rev;

   phase_timer #(
      .PHASE_CYCLES(PHASE_CYCLES)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timer_clear),
      .expire(expire)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: abort takes priority over a phase ending on the same edge.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (cmd_valid) state_next = P1;
         P1: begin
            if (back_out)    state_next = GAP;
            else if (expire) state_next = rev ? GAP : P2;
         end
         P2: begin
            if (back_out)    state_next = P1;
            else if (expire) state_next = rev ? P1 : P3;
         end
         P3: begin
            if (back_out)    state_next = P2;
            else if (expire) state_next = GAP;
         end
         GAP: if (expire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode: registered outputs are computed from the state being entered.
   always_comb begin
      dir_next     = accept ? cmd_dir : dir;
      rev_next     = rev;
      if (state_next == IDLE) begin
         rev_next = 1'b0;
      end else if (in_phase && abort) begin
         rev_next = 1'b1;
      end
      ab_next      = phase_ab(state_next, dir_next);
      done_next    = (state == P3) && (state_next == GAP);
      aborted_next = (state == P1) && (state_next == GAP);
      busy_next    = (state_next != IDLE);
      timer_clear  = (state_next != state) || (state == IDLE);
   end

   // Output and context registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a       <= 1'b0;
         b       <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         busy    <= 1'b0;
         dir     <= 1'b0;
         rev     <= 1'b0;
      end else begin
         {a, b}  <= ab_next;
         done    <= done_next;
         aborted <= aborted_next;
         busy    <= busy_next;
         dir     <= dir_next;
         rev     <= rev_next;
      end
   end

endmodule

// File: tb/tb_car_sensor_emulator.sv
// Bench for car_sensor_emulator: directed table, async-reset sequence, random stress.
module tb_car_sensor_emulator;

   localparam int PH = 4;

   logic clk       = 1'b0;
   logic reset     = 1'b0;
   logic cmd_valid = 1'b0;
   logic cmd_dir   = 1'b0;
   logic abort     = 1'b0;
   logic cmd_ready;
   logic a;
   logic b;
   logic busy;
   logic done;
   logic aborted;

   car_sensor_emulator #(
      .PHASE_CYCLES(PH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_dir  (cmd_dir),
      .cmd_ready(cmd_ready),
      .abort    (abort),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .aborted  (aborted)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [1:0] prev_ab = 2'b00;
   int done_total  = 0;
   int model_count = 0;
   int model_events = 0;

   // Loopback car detector: a full 10,11,01 pass is an entry, 01,11,10 an exit.
   int loop_count  = 0;
   int loop_events = 0;
   logic [1:0] seq[$];
   logic [1:0] last_ab = 2'b00;

   always @(negedge clk) begin
      if ({a, b} != last_ab) begin
         if ({a, b} == 2'b00) begin
            if (seq.size() == 3) begin
               if (seq[0] == 2'b10 && seq[1] == 2'b11 && seq[2] == 2'b01) begin
                  loop_count++;
                  loop_events++;
               end else if (seq[0] == 2'b01 && seq[1] == 2'b11 && seq[2] == 2'b10) begin
                  if (loop_count > 0) loop_count--;
                  loop_events++;
               end
            end
            seq.delete();
         end else begin
            seq.push_back({a, b});
         end
         last_ab = {a, b};
      end
   end

   typedef struct {
      logic dir;
      int   k;
      logic ab_acc;
      int   exp_len;
      int   exp_done;
      int   exp_abt;
      int   exp_count;
   } vec_t;

   vec_t tbl[10];

   // Expected per-cycle {a,b,done,aborted} after accept.
   logic [3:0] exp_q[$];

   function automatic logic [5:0] outs();
      return {cmd_ready, busy, a, b, done, aborted};
   endfunction

   task automatic cmp_vec(input string nm, input logic [5:0] act, input logic [5:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t {ready,busy,a,b,done,aborted} got %b expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic cmp_int(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic observe(input string nm, input logic [5:0] exp);
      logic [5:0] o;
      o = outs();
      cmp_vec(nm, o, exp);
      n_cmp++;
      if ((prev_ab ^ o[3:2]) == 2'b11) begin
         n_bad++;
         $display("FAIL gray_step t=%0t ab %b -> %b, required a one-bit change", $time, prev_ab, o[3:2]);
      end
      n_cmp++;
      if (o[1] && o[0]) begin
         n_bad++;
         $display("FAIL pulse_excl t=%0t done=%b aborted=%b, required not both", $time, o[1], o[0]);
      end
      prev_ab = o[3:2];
      if (o[1]) done_total++;
   endtask

   // Trace from the protocol rules: k is the cycle abort is high (0 = none).
   function automatic void build_trace(input logic d, input int k);
      logic [1:0] code[3];
      int p;
      exp_q.delete();
      if (d == 1'b0) begin
         code[0] = 2'b10; code[1] = 2'b11; code[2] = 2'b01;
      end else begin
         code[0] = 2'b01; code[1] = 2'b11; code[2] = 2'b10;
      end
      if (k == 0 || k > 3 * PH) begin
         for (int c = 0; c < 3 * PH; c++) exp_q.push_back({code[c / PH], 2'b00});
         exp_q.push_back(4'b0010);
         repeat (PH - 1) exp_q.push_back(4'b0000);
      end else begin
         p = (k - 1) / PH;
         for (int c = 0; c < k; c++) exp_q.push_back({code[c / PH], 2'b00});
         for (int q = p - 1; q >= 0; q--) repeat (PH) exp_q.push_back({code[q], 2'b00});
         exp_q.push_back(4'b0001);
         repeat (PH - 1) exp_q.push_back(4'b0000);
      end
   endfunction

   // Issue one command from idle and check every cycle until idle again.
   task automatic run_cmd(input logic d, input int k, input logic ab_acc, input bit noisy,
                          output int n_busy, output int n_done, output int n_abt);
      int len;
      logic [5:0] o;
      build_trace(d, k);
      len = exp_q.size();
      n_busy = 0; n_done = 0; n_abt = 0;
      cmd_valid = 1'b1; cmd_dir = d; abort = ab_acc;
      @(negedge clk);
      observe("accept_idle", 6'b100000);
      @(posedge clk); #1;
      for (int c = 1; c <= 65; c++) begin
         if (c == 65) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout got no idle within 64 cycles expected %0d busy cycles", len);
            break;
         end
         cmd_valid = (c <= len) ? (noisy ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
         cmd_dir   = 1'($urandom_range(0, 1));
         abort     = (c == k);
         @(negedge clk);
         if (c <= len) observe("seq", {2'b01, exp_q[c - 1]});
         else          observe("seq_end", 6'b100000);
         o = outs();
         if (o[4]) n_busy++;
         if (o[1]) n_done++;
         if (o[0]) n_abt++;
         if (o[5] || c > len) break;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0; abort = 1'b0;
      @(posedge clk); #1;
      if (k == 0 || k > 3 * PH) begin
         model_events++;
         if (d == 1'b0) model_count++;
         else if (model_count > 0) model_count--;
      end
   endtask

   initial begin
      int nb, nd, na;
      logic d;
      int k;
      bit completes;

      tbl[0] = '{1'b0,  0, 1'b1, 16, 1, 0, 1};
      tbl[1] = '{1'b1,  0, 1'b0, 16, 1, 0, 0};
      tbl[2] = '{1'b1,  0, 1'b0, 16, 1, 0, 0};
      tbl[3] = '{1'b0,  7, 1'b0, 15, 0, 1, 0};
      tbl[4] = '{1'b0,  2, 1'b0,  6, 0, 1, 0};
      tbl[5] = '{1'b0, 14, 1'b0, 16, 1, 0, 1};
      tbl[6] = '{1'b1, 10, 1'b0, 22, 0, 1, 1};
      tbl[7] = '{1'b0,  4, 1'b0,  8, 0, 1, 1};
      tbl[8] = '{1'b0,  8, 1'b0, 16, 0, 1, 1};
      tbl[9] = '{1'b0, 12, 1'b0, 24, 0, 1, 1};

      // Reset state, then release.
      @(negedge clk);
      observe("reset_state", 6'b100000);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      observe("post_reset", 6'b100000);
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         run_cmd(tbl[i].dir, tbl[i].k, tbl[i].ab_acc, 1'b0, nb, nd, na);
         cmp_int($sformatf("tbl%0d_busy_cycles", i), nb, tbl[i].exp_len);
         cmp_int($sformatf("tbl%0d_done", i), nd, tbl[i].exp_done);
         cmp_int($sformatf("tbl%0d_aborted", i), na, tbl[i].exp_abt);
         cmp_int($sformatf("tbl%0d_loop_count", i), loop_count, tbl[i].exp_count);
      end

      // Asynchronous reset in cycle 6 of an entry.
      cmd_valid = 1'b1; cmd_dir = 1'b0; abort = 1'b0;
      @(negedge clk);
      observe("rst_accept", 6'b100000);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         observe("rst_run", (c <= PH) ? 6'b011000 : 6'b011100);
         @(posedge clk); #1;
      end
      #2 reset = 1'b0;
      #1 cmp_vec("rst_async", outs(), 6'b100000);
      prev_ab = 2'b00;
      @(negedge clk);
      observe("rst_hold", 6'b100000);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      run_cmd(1'b0, 0, 1'b0, 1'b0, nb, nd, na);
      cmp_int("rst_rerun_busy_cycles", nb, 16);
      cmp_int("rst_rerun_done", nd, 1);
      cmp_int("rst_rerun_loop_count", loop_count, 2);

      // Random stress with idle-time abort noise.
      for (int i = 0; i < 1000; i++) begin
         int g;
         g = $urandom_range(0, 2);
         for (int j = 0; j < g; j++) begin
            cmd_valid = 1'b0;
            abort = 1'($urandom_range(0, 1));
            @(negedge clk);
            observe("idle_gap", 6'b100000);
            @(posedge clk); #1;
         end
         d = 1'($urandom_range(0, 1));
         k = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 16));
         completes = (k == 0 || k > 3 * PH);
         run_cmd(d, k, 1'($urandom_range(0, 1)), 1'b1, nb, nd, na);
         cmp_int("stress_done", nd, completes ? 1 : 0);
         cmp_int("stress_aborted", na, completes ? 0 : 1);
      end

      cmp_int("final_loop_count", loop_count, model_count);
      cmp_int("final_loop_events", loop_events, model_events);
      cmp_int("done_vs_loop_events", done_total, loop_events);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
